// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute stage: opcode map, PSR flag bit
// positions and the default datapath width.
package alu_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int OP_W          = 4;
  localparam int NFLAGS        = 5;

  localparam logic [OP_W-1:0] OP_NOP  = 4'b0000;
  localparam logic [OP_W-1:0] OP_AND  = 4'b0001;
  localparam logic [OP_W-1:0] OP_OR   = 4'b0010;
  localparam logic [OP_W-1:0] OP_XOR  = 4'b0011;
  localparam logic [OP_W-1:0] OP_MOV  = 4'b0100;
  localparam logic [OP_W-1:0] OP_ADD  = 4'b0101;
  localparam logic [OP_W-1:0] OP_ADDU = 4'b0110;
  localparam logic [OP_W-1:0] OP_ADDC = 4'b0111;
  localparam logic [OP_W-1:0] OP_CMPU = 4'b1000;
  localparam logic [OP_W-1:0] OP_SUB  = 4'b1001;
  localparam logic [OP_W-1:0] OP_SUBC = 4'b1010;
  localparam logic [OP_W-1:0] OP_CMP  = 4'b1011;

  localparam int FLAG_C = 0;
  localparam int FLAG_L = 1;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 4;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: result and updated PSR for one operation. Flags an
// opcode does not write pass through from psr_in unchanged.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [OP_W-1:0]   op,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic              carry_in,
  input  logic [NFLAGS-1:0] psr_in,
  output logic [WIDTH-1:0]  c,
  output logic [NFLAGS-1:0] psr_out
);

  localparam int MSB = WIDTH - 1;

  logic             add_cin;
  logic             sub_bin;
  logic [WIDTH:0]   sum_x;
  logic [WIDTH:0]   diff_x;
  logic             add_ovf;
  logic             sub_ovf;
  logic [WIDTH-1:0] logic_res;

  // Extended-width arithmetic: the top bit is carry-out for adds and borrow for subtracts.
  assign add_cin = (op == OP_ADDC) ? carry_in : 1'b0;
  assign sub_bin = (op == OP_SUBC) ? carry_in : 1'b0;
  assign sum_x   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, add_cin};
  assign diff_x  = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, sub_bin};
  assign add_ovf = (a[MSB] == b[MSB]) && (sum_x[MSB]  != a[MSB]);
  assign sub_ovf = (a[MSB] != b[MSB]) && (diff_x[MSB] != a[MSB]);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    c         = '0;
    psr_out   = psr_in;
    logic_res = '0;
    unique case (op)
      OP_AND, OP_OR, OP_XOR: begin
        if (op == OP_AND)     logic_res = a & b;
        else if (op == OP_OR) logic_res = a | b;
        else                  logic_res = a ^ b;
        c               = logic_res;
        psr_out[FLAG_Z] = (logic_res == '0);
      end
      OP_MOV: c = b;
      OP_ADD, OP_ADDC: begin
        c               = sum_x[MSB:0];
        psr_out[FLAG_C] = sum_x[WIDTH];
        psr_out[FLAG_F] = add_ovf;
      end
      OP_ADDU: begin
        c               = sum_x[MSB:0];
        psr_out[FLAG_C] = sum_x[WIDTH];
      end
      OP_SUB, OP_SUBC: begin
        c               = diff_x[MSB:0];
        psr_out[FLAG_C] = diff_x[WIDTH];
        psr_out[FLAG_F] = sub_ovf;
      end
      OP_CMPU: begin
        psr_out[FLAG_L] = (a < b);
        psr_out[FLAG_Z] = (a == b);
      end
      OP_CMP: begin
        psr_out[FLAG_L] = (a < b);
        psr_out[FLAG_N] = ($signed(a) < $signed(b));
        psr_out[FLAG_Z] = (a == b);
      end
      default: ;  // NOP and reserved opcodes: C=0, flags untouched
    endcase
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Two-stage pipelined ALU execute unit with valid/ready on both sides and a
// persistent PSR that is updated as each op moves from stage 1 into stage 2.
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_opcode,
  input  logic [WIDTH-1:0]  in_a,
  input  logic [WIDTH-1:0]  in_b,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_c,
  output logic [NFLAGS-1:0] out_flags,
  output logic [TAG_W-1:0]  out_tag,
  output logic [NFLAGS-1:0] psr,
  output logic              busy
);

  logic              s1_valid_q, s1_valid_d;
  logic [OP_W-1:0]   s1_op_q,    s1_op_d;
  logic [WIDTH-1:0]  s1_a_q,     s1_a_d;
  logic [WIDTH-1:0]  s1_b_q,     s1_b_d;
  logic [TAG_W-1:0]  s1_tag_q,   s1_tag_d;

  logic              s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0]  s2_c_q,     s2_c_d;
  logic [NFLAGS-1:0] s2_flags_q, s2_flags_d;
  logic [TAG_W-1:0]  s2_tag_q,   s2_tag_d;

  logic [NFLAGS-1:0] psr_q,      psr_d;

  logic              adv;
  logic              accept;
  logic [WIDTH-1:0]  core_c;
  logic [NFLAGS-1:0] core_psr;

  // S1 moves on whenever S2 is empty or being drained this edge.
  assign adv      = s1_valid_q && (!s2_valid_q || out_ready);
  assign in_ready = !s1_valid_q || adv;
  assign accept   = in_valid && in_ready;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .op       (s1_op_q),
    .a        (s1_a_q),
    .b        (s1_b_q),
    .carry_in (psr_q[FLAG_C]),
    .psr_in   (psr_q),
    .c        (core_c),
    .psr_out  (core_psr)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_tag_d   = s1_tag_q;
    s2_valid_d = s2_valid_q;
    s2_c_d     = s2_c_q;
    s2_flags_d = s2_flags_q;
    s2_tag_d   = s2_tag_q;
    psr_d      = psr_q;

    if (accept) begin
      s1_valid_d = 1'b1;
      s1_op_d    = in_opcode;
      s1_a_d     = in_a;
      s1_b_d     = in_b;
      s1_tag_d   = in_tag;
    end else if (adv) begin
      s1_valid_d = 1'b0;
    end

    if (adv) begin
      s2_valid_d = 1'b1;
      s2_c_d     = core_c;
      s2_flags_d = core_psr;
      s2_tag_d   = s1_tag_q;
      psr_d      = core_psr;
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= OP_NOP;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_c_q     <= '0;
      s2_flags_q <= '0;
      s2_tag_q   <= '0;
      psr_q      <= '0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values of the others.
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_tag_q   <= s1_tag_d;
      s2_valid_q <= s2_valid_d;
      s2_c_q     <= s2_c_d;
      s2_flags_q <= s2_flags_d;
      s2_tag_q   <= s2_tag_d;
      psr_q      <= psr_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_c     = s2_c_q;
  assign out_flags = s2_flags_q;
  assign out_tag   = s2_tag_q;
  assign psr       = psr_q;
  assign busy      = s1_valid_q || s2_valid_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: single ops with hand-computed results,
// a back-pressured stream, and reset with both stages occupied.
module tb_alu_exec_stage;
  import alu_pkg::*;

  localparam int WIDTH = 16;
  localparam int TAG_W = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_opcode;
  logic [WIDTH-1:0]  in_a;
  logic [WIDTH-1:0]  in_b;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_c;
  logic [4:0]        out_flags;
  logic [TAG_W-1:0]  out_tag;
  logic [4:0]        psr;
  logic              busy;

  int n_checks = 0;
  int n_errors = 0;

  // Completed results: {tag, flags, c}
  logic [TAG_W+5+WIDTH-1:0] res_q[$];

  alu_exec_stage #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_opcode (in_opcode),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_c     (out_c),
    .out_flags (out_flags),
    .out_tag   (out_tag),
    .psr       (psr),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Output monitor: records transfers and verifies outputs hold while stalled.
  logic             prev_stall = 1'b0;
  logic [WIDTH-1:0] held_c;
  logic [TAG_W-1:0] held_tag;
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_c", out_c, held_c);
        check("hold_tag", out_tag, held_tag);
      end
      if (out_valid && out_ready) res_q.push_back({out_tag, out_flags, out_c});
      prev_stall = out_valid && !out_ready;
      held_c     = out_c;
      held_tag   = out_tag;
    end
  end

  // Present one request and hold it until it transfers (bounded).
  task automatic send(input logic [3:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic [TAG_W-1:0] tg, output int tries);
    logic ok;
    ok        = 1'b0;
    tries     = 0;
    in_valid  = 1'b1;
    in_opcode = op;
    in_a      = a;
    in_b      = b;
    in_tag    = tg;
    while (!ok && tries < 20) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      tries++;
    end
    if (!ok) check("accept_timeout", 32'(ok), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [3:0] op, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] tg,
                        input logic [WIDTH-1:0] exp_c, input logic [4:0] exp_f);
    int tries;
    send(op, a, b, tg, tries);
    check({name, "_lat"}, out_valid, 0);
    check({name, "_busy"}, busy, 1);
    @(posedge clk);
    #1;
    check({name, "_valid"}, out_valid, 1);
    check({name, "_c"}, out_c, exp_c);
    check({name, "_flags"}, out_flags, exp_f);
    check({name, "_psr"}, psr, exp_f);
    check({name, "_tag"}, out_tag, tg);
  endtask

  logic [3:0]       s_op [4] = '{OP_OR, OP_MOV, OP_SUB, OP_ADD};
  logic [WIDTH-1:0] s_a  [4] = '{16'h0F00, 16'h0000, 16'h0005, 16'hFFFF};
  logic [WIDTH-1:0] s_b  [4] = '{16'h00F0, 16'hABCD, 16'h0003, 16'hFFFF};
  logic [WIDTH-1:0] s_c  [4] = '{16'h0FF0, 16'hABCD, 16'h0002, 16'hFFFE};
  logic [4:0]       s_f  [4] = '{5'b10010, 5'b10010, 5'b10010, 5'b10011};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int tries;
    int first_stall;
    logic [TAG_W+5+WIDTH-1:0] e;

    reset_n   = 1'b1;
    in_valid  = 1'b0;
    in_opcode = '0;
    in_a      = '0;
    in_b      = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_psr", psr, 0);
    check("rst_out_c", out_c, 0);
    check("rst_out_flags", out_flags, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // flags are {N,Z,F,L,C}
    run_op("add_ovf", OP_ADD,  16'h7FFF, 16'h0001, 4'h1, 16'h8000, 5'b00100);
    run_op("addu",    OP_ADDU, 16'hFFFF, 16'h0001, 4'h2, 16'h0000, 5'b00101);
    run_op("addc",    OP_ADDC, 16'h0001, 16'h0001, 4'h3, 16'h0003, 5'b00000);
    run_op("cmp",     OP_CMP,  16'hFFFF, 16'h0000, 4'h4, 16'h0000, 5'b10000);
    run_op("cmpu",    OP_CMPU, 16'h0000, 16'hFFFF, 4'h5, 16'h0000, 5'b10010);
    run_op("and",     OP_AND,  16'h00F0, 16'h0F00, 4'h6, 16'h0000, 5'b11010);
    run_op("xor",     OP_XOR,  16'hFFFF, 16'h0F0F, 4'h7, 16'hF0F0, 5'b10010);
    run_op("mov",     OP_MOV,  16'h5555, 16'h1234, 4'h8, 16'h1234, 5'b10010);
    run_op("rsvd",    4'b1110, 16'hFFFF, 16'hFFFF, 4'h9, 16'h0000, 5'b10010);

    // Back-pressured stream: consumer stalls for the first three cycles.
    @(posedge clk);
    #1;
    res_q.delete();
    first_stall = -1;
    fork
      begin
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
      begin
        for (int i = 0; i < 4; i++) begin
          send(s_op[i], s_a[i], s_b[i], 4'(i + 1), tries);
          if (tries > 1 && first_stall < 0) first_stall = i;
        end
      end
    join
    check("stream_first_stall", first_stall, 2);
    for (int i = 0; i < 30 && res_q.size() < 4; i++) @(posedge clk);
    #1;
    check("stream_count", res_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < res_q.size()) begin
        e = res_q[i];
        check("stream_tag", e[TAG_W+5+WIDTH-1 -: TAG_W], i + 1);
        check("stream_flags", e[WIDTH+4 -: 5], s_f[i]);
        check("stream_c", e[WIDTH-1:0], s_c[i]);
      end
    end

    // Fill both stages, then reset mid-cycle.
    out_ready = 1'b0;
    send(OP_ADD, 16'h0001, 16'h0001, 4'hA, tries);
    send(OP_MOV, 16'h0000, 16'h7777, 4'hB, tries);
    check("full_busy", busy, 1);
    check("full_out_valid", out_valid, 1);
    check("full_in_ready", in_ready, 0);
    res_q.delete();
    #3 reset_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_psr", psr, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_busy", busy, 0);
    check("midrst_out_c", out_c, 0);
    @(negedge clk) reset_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("postrst_out_valid", out_valid, 0);
    check("postrst_no_emit", res_q.size(), 0);

    run_op("sub",  OP_SUB,  16'h0003, 16'h0005, 4'hC, 16'hFFFE, 5'b00001);
    run_op("subc", OP_SUBC, 16'h8000, 16'h0001, 4'hD, 16'h7FFE, 5'b00100);
    run_op("nop",  OP_NOP,  16'h1234, 16'h4321, 4'hE, 16'h0000, 5'b00100);

    @(posedge clk);
    #1;
    check("drain_out_valid", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
